// File: rtl/lenet_result_reader.sv
// Reads both FC2 score sets out of SRAM F, streams them as int8 bytes over valid/ready
// and reports the per-set argmax class once the last byte has been accepted.

module lenet_argmax_lane (
    input  logic       clk,
    input  logic       srst,
    input  logic       upd,
    input  logic [7:0] data,
    input  logic [3:0] idx,
    output logic [3:0] best_idx
);
    logic signed [7:0] max_val;
    logic [3:0]        max_idx;
    logic              take;

    // Index 0 seeds the running max; later bytes win only when strictly greater,
    // so ties keep the lowest index.
    assign take     = upd && ((idx == 4'd0) || ($signed(data) > max_val));
    assign best_idx = take ? idx : max_idx;

    always_ff @(posedge clk) begin
        if (srst) begin
            max_val <= '0;
            max_idx <= '0;
        end else if (take) begin
            max_val <= data;
            max_idx <= idx;
        end
    end
endmodule

module lenet_result_reader #(
    parameter int NUM_CLASS = 10,
    parameter int WORDS     = 3
) (
    input  logic        clk,
    input  logic        srst,
    input  logic        fc2_done,
    output logic [1:0]  sram_raddr_f,
    input  logic [31:0] sram_rdata_f,
    input  logic [31:0] sram_rdata_f_1,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_set,
    output logic [3:0]  out_idx,
    output logic        out_last,
    output logic        busy,
    output logic        result_valid,
    output logic [3:0]  result_class0,
    output logic [3:0]  result_class1
);
    localparam logic [3:0] LAST_IDX  = 4'(NUM_CLASS - 1);
    localparam logic [2:0] LAST_FCNT = 3'(WORDS);

    typedef enum logic [1:0] {IDLE, FETCH, STREAM, DONE} state_t;

    state_t                 state, state_nxt;
    logic [2:0]             fcnt;
    logic [1:0]             wr_word;
    logic [1:0][3:0][31:0]  cap_buf;
    logic                   set_q;
    logic [3:0]             idx_q;
    logic                   hs;
    logic [31:0]            cur_word;
    logic [7:0]             cur_byte;
    logic [1:0][3:0]        best_idx;

    // fcnt counts FETCH cycles; the word landing in cycle fcnt was addressed in fcnt-1.
    assign wr_word  = fcnt[1:0] - 2'd1;
    assign hs       = out_valid & out_ready;
    assign cur_word = cap_buf[set_q][idx_q[3:2]];
    assign cur_byte = cur_word[{~idx_q[1:0], 3'b000} +: 8];

    assign out_valid    = (state == STREAM);
    assign out_data     = out_valid ? cur_byte : 8'd0;
    assign out_set      = set_q;
    assign out_idx      = idx_q;
    assign out_last     = out_valid && set_q && (idx_q == LAST_IDX);
    assign busy         = (state != IDLE);
    assign result_valid = (state == DONE);

    always_ff @(posedge clk) begin
        if (srst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (fc2_done)           state_nxt = FETCH;
            FETCH:   if (fcnt == LAST_FCNT)  state_nxt = STREAM;
            STREAM:  if (hs && out_last)     state_nxt = DONE;
            DONE:                            state_nxt = IDLE;
            default:                         state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            fcnt          <= '0;
            sram_raddr_f  <= '0;
            cap_buf       <= '0;
            set_q         <= 1'b0;
            idx_q         <= '0;
            result_class0 <= '0;
            result_class1 <= '0;
        end else begin
            case (state)
                IDLE: begin
                    fcnt         <= '0;
                    sram_raddr_f <= '0;
                    set_q        <= 1'b0;
                    idx_q        <= '0;
                end
                FETCH: begin
                    fcnt <= fcnt + 3'd1;
                    if (({1'b0, fcnt} + 4'd1) < 4'(WORDS))
                        sram_raddr_f <= fcnt[1:0] + 2'd1;
                    else
                        sram_raddr_f <= '0;
                    if (fcnt != 3'd0) begin
                        cap_buf[0][wr_word] <= sram_rdata_f;
                        cap_buf[1][wr_word] <= sram_rdata_f_1;
                    end
                end
                STREAM: if (hs) begin
                    if (idx_q == LAST_IDX) begin
                        idx_q <= '0;
                        set_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q + 4'd1;
                    end
                    // best_idx folds in the byte being accepted this cycle.
                    if (out_last) begin
                        result_class0 <= best_idx[0];
                        result_class1 <= best_idx[1];
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar s = 0; s < 2; s++) begin : g_set
        lenet_argmax_lane u_lane (
            .clk      (clk),
            .srst     (srst),
            .upd      (hs && (set_q == 1'(s))),
            .data     (cur_byte),
            .idx      (idx_q),
            .best_idx (best_idx[s])
        );
    end
endmodule

// File: tb/tb_lenet_result_reader.sv
// Bench for lenet_result_reader: SRAM F model, byte-stream scoreboard and argmax
// reference computed directly from the stored words.

module tb_lenet_result_reader;
    localparam int NC = 10;
    localparam int W  = 3;

    logic        clk = 0;
    logic        srst = 0;
    logic        fc2_done = 0;
    logic [1:0]  sram_raddr_f;
    logic [31:0] sram_rdata_f = 0, sram_rdata_f_1 = 0;
    logic        out_valid, out_ready = 0;
    logic [7:0]  out_data;
    logic        out_set, out_last, busy, result_valid;
    logic [3:0]  out_idx, result_class0, result_class1;

    logic [31:0] mem0 [4];
    logic [31:0] mem1 [4];
    int n_cmp = 0, n_bad = 0;

    lenet_result_reader #(.NUM_CLASS(NC), .WORDS(W)) dut (
        .clk(clk), .srst(srst), .fc2_done(fc2_done), .sram_raddr_f(sram_raddr_f),
        .sram_rdata_f(sram_rdata_f), .sram_rdata_f_1(sram_rdata_f_1),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_set(out_set), .out_idx(out_idx), .out_last(out_last), .busy(busy),
        .result_valid(result_valid), .result_class0(result_class0),
        .result_class1(result_class1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        sram_rdata_f   <= mem0[sram_raddr_f];
        sram_rdata_f_1 <= mem1[sram_raddr_f];
    end

    function automatic logic [7:0] exp_byte(input int s, input int c);
        logic [31:0] w;
        w = s ? mem1[c / 4] : mem0[c / 4];
        return 8'(w >> (8 * (3 - (c % 4))));
    endfunction

    function automatic logic [3:0] exp_argmax(input int s);
        int best = 0;
        for (int c = 1; c < NC; c++)
            if ($signed(exp_byte(s, c)) > $signed(exp_byte(s, best))) best = c;
        return 4'(best);
    endfunction

    // One full run. abort_after>0 returns right after that many handshakes.
    task automatic run_stream(input string name, input bit rand_ready, input int pulse_a,
                              input int pulse_b, input int abort_after, input bit done_pulse);
        int k = 0, cyc = 1, first_v = -1, stall = 0, rv = 0;
        bit held = 0;
        logic [7:0] h_data; logic h_set, h_last; logic [3:0] h_idx;
        logic [3:0] e0, e1;
        e0 = exp_argmax(0); e1 = exp_argmax(1);
        @(negedge clk); fc2_done = 1;
        @(negedge clk); fc2_done = 0;
        while (k < 2 * NC && cyc < 2000) begin
            n_cmp++;
            if (busy !== 1'b1) begin n_bad++; $display("FAIL %s busy cyc %0d got %b want 1", name, cyc, busy); end
            if (cyc <= W + 1) begin
                n_cmp++;
                if (sram_raddr_f !== 2'((cyc <= W) ? cyc - 1 : 0)) begin
                    n_bad++; $display("FAIL %s raddr cyc %0d got %0d", name, cyc, sram_raddr_f);
                end
            end
            if (result_valid) rv++;
            if (out_valid && first_v < 0) first_v = cyc;
            if (held) begin
                n_cmp++;
                if ({out_valid, out_data, out_set, out_idx, out_last} !== {1'b1, h_data, h_set, h_idx, h_last}) begin
                    n_bad++; $display("FAIL %s stall_hold cyc %0d got %h/%b/%0d want %h/%b/%0d",
                                      name, cyc, out_data, out_set, out_idx, h_data, h_set, h_idx);
                end
            end
            fc2_done = (cyc == pulse_a || cyc == pulse_b);
            if (!rand_ready) out_ready = 1;
            else if (stall > 0) begin out_ready = 0; stall--; end
            else if ($urandom_range(7) == 0) begin out_ready = 0; stall = 4; end
            else out_ready = 1'($urandom_range(1));
            if (out_valid && out_ready) begin
                n_cmp++;
                if ({out_data, out_set, out_idx, out_last} !==
                    {exp_byte(k / NC, k % NC), 1'(k / NC), 4'(k % NC), (k == 2 * NC - 1)}) begin
                    n_bad++; $display("FAIL %s byte%0d got %h/%b/%0d/%b want %h/%0d/%0d", name, k,
                                      out_data, out_set, out_idx, out_last, exp_byte(k / NC, k % NC), k / NC, k % NC);
                end
                k++; held = 0;
            end else if (out_valid) begin
                held = 1; h_data = out_data; h_set = out_set; h_idx = out_idx; h_last = out_last;
            end
            @(negedge clk); cyc++;
            if (abort_after > 0 && k == abort_after) break;
        end
        fc2_done = 0;
        n_cmp++;
        if (rv != 0) begin n_bad++; $display("FAIL %s early_result_valid got %0d want 0", name, rv); end
        if (abort_after > 0) return;
        n_cmp++;
        if (k != 2 * NC) begin n_bad++; $display("FAIL %s timeout bytes got %0d want %0d", name, k, 2 * NC); end
        if (!rand_ready) begin
            n_cmp++;
            if (first_v != W + 2) begin n_bad++; $display("FAIL %s latency got %0d want %0d", name, first_v, W + 2); end
        end
        n_cmp++;
        if ({result_valid, out_valid, result_class0, result_class1} !== {1'b1, 1'b0, e0, e1}) begin
            n_bad++; $display("FAIL %s result got rv=%b ov=%b c0=%0d c1=%0d want 1 0 %0d %0d",
                              name, result_valid, out_valid, result_class0, result_class1, e0, e1);
        end
        fc2_done = done_pulse;
        @(negedge clk); fc2_done = 0;
        n_cmp++;
        if ({busy, result_valid} !== 2'b00) begin n_bad++; $display("FAIL %s post_done busy=%b rv=%b want 0 0", name, busy, result_valid); end
        rv = 0;
        for (int i = 0; i < 3; i++) begin @(negedge clk); if (result_valid || busy) rv++; end
        n_cmp++;
        if (rv != 0 || result_class0 !== e0 || result_class1 !== e1) begin
            n_bad++; $display("FAIL %s idle_hold got extra=%0d c0=%0d c1=%0d want 0 %0d %0d",
                              name, rv, result_class0, result_class1, e0, e1);
        end
    endtask

    task automatic check_reset_vals(input string name);
        n_cmp++;
        if ({sram_raddr_f, out_valid, out_data, out_set, out_idx, out_last, busy, result_valid,
             result_class0, result_class1} !== '0) begin
            n_bad++; $display("FAIL %s reset_vals got raddr=%0d ov=%b d=%h set=%b idx=%0d last=%b busy=%b rv=%b c0=%0d c1=%0d want all 0",
                              name, sram_raddr_f, out_valid, out_data, out_set, out_idx, out_last,
                              busy, result_valid, result_class0, result_class1);
        end
    endtask

    task automatic load_basic();
        mem0[0] = 32'h01020304; mem0[1] = 32'h05067F08; mem0[2] = 32'h090A0000; mem0[3] = 0;
        mem1[0] = 32'h80818283; mem1[1] = 32'h84858687; mem1[2] = 32'h88890000; mem1[3] = 0;
    endtask

    task automatic test_reset();
        srst = 1; repeat (2) @(negedge clk); srst = 0;
        check_reset_vals("reset");
    endtask

    task automatic test_basic();
        load_basic();
        run_stream("basic", 0, -1, -1, 0, 0);
        n_cmp++;
        if (result_class0 !== 4'd6 || result_class1 !== 4'd9) begin
            n_bad++; $display("FAIL basic_const got %0d %0d want 6 9", result_class0, result_class1);
        end
    endtask

    task automatic test_ties();
        for (int i = 0; i < 4; i++) begin mem0[i] = 32'hF0F0F0F0; mem1[i] = 0; end
        mem1[0] = 32'h00001000; mem1[1] = 32'h00000010;
        run_stream("ties", 0, -1, -1, 0, 0);
        n_cmp++;
        if (result_class0 !== 4'd0 || result_class1 !== 4'd2) begin
            n_bad++; $display("FAIL ties_const got %0d %0d want 0 2", result_class0, result_class1);
        end
    endtask

    task automatic test_backpressure();
        load_basic();
        run_stream("backpressure", 1, -1, -1, 0, 0);
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 4; i++) begin mem0[i] = $urandom; mem1[i] = $urandom; end
            run_stream("bp_random", 1, -1, -1, 0, 0);
        end
    endtask

    task automatic test_start_busy();
        for (int i = 0; i < 4; i++) begin mem0[i] = $urandom; mem1[i] = $urandom; end
        run_stream("start_busy", 0, 2, 8, 0, 1);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) begin mem0[i] = $urandom; mem1[i] = $urandom; end
        run_stream("reset_mid", 0, -1, -1, 7, 0);
        srst = 1; @(negedge clk);
        check_reset_vals("reset_mid");
        srst = 0; @(negedge clk);
        n_cmp++;
        if (result_valid !== 1'b0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL reset_mid_after got rv=%b busy=%b want 0 0", result_valid, busy);
        end
        run_stream("after_reset", 0, -1, -1, 0, 0);
    endtask

    task automatic test_ignored_lanes();
        for (int i = 0; i < 4; i++) begin mem0[i] = $urandom & 32'h3F3F3F3F; mem1[i] = $urandom & 32'h3F3F3F3F; end
        mem0[2] = mem0[2] | 32'h00007F7F; mem1[2] = mem1[2] | 32'h00007F7F;
        run_stream("ignored_lanes", 1, -1, -1, 0, 0);
        n_cmp++;
        if (result_class0 > 4'd9 || result_class1 > 4'd9) begin
            n_bad++; $display("FAIL ignored_lanes_range got %0d %0d want <=9", result_class0, result_class1);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin mem0[i] = 0; mem1[i] = 0; end
        test_reset();
        test_basic();
        test_ties();
        test_backpressure();
        test_start_busy();
        test_reset_mid();
        test_ignored_lanes();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
